// File: rtl/instr_defs_pkg.sv
// Shared decode-stage types: register addresses, the scoreboard vector and
// the issue FSM states.
package instr_defs;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]          reg_addr_t;
  typedef logic [NUM_REGS-1:0] scoreboard_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } issue_fsm_e;

  function automatic scoreboard_t reg_onehot(input reg_addr_t addr);
    scoreboard_t oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy-register scoreboard for in-flight loads, with same-cycle writeback
// bypass and a count of outstanding loads.
module id_scoreboard
  import instr_defs::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load_issue,
  input  reg_addr_t                            load_rd,
  input  logic                                 wb_valid,
  input  reg_addr_t                            wb_rd_addr,
  output scoreboard_t                          busy,
  output scoreboard_t                          eb,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 full
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  scoreboard_t clr;
  scoreboard_t set;
  logic        dec;

  always_comb begin
    clr   = wb_valid ? reg_onehot(wb_rd_addr) : '0;
    set   = (load_issue && (load_rd != '0)) ? reg_onehot(load_rd) : '0;
    dec   = wb_valid && (outstanding != '0);
    eb    = busy & ~clr;
    eb[0] = 1'b0;
    full  = (outstanding == CW'(MAX_OUTSTANDING));
  end

  // Clear is applied before set so a same-cycle set of the same register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy <= (busy & ~clr) | set;
      case ({load_issue, dec})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // A writeback with nothing in flight points at a broken memory pipeline.
  a_no_wb_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(wb_valid && (outstanding == '0))
  );

endmodule

// File: rtl/id_issue_ctl.sv
// D1->E issue/stall controller: hazard detection against the load scoreboard,
// flush bubble sequencing and a saturating stall counter.
module id_issue_ctl
  import instr_defs::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid_d1,
  input  logic                                 rs1_en_d1,
  input  logic                                 rs2_en_d1,
  input  reg_addr_t                            rs1_addr_d1,
  input  reg_addr_t                            rs2_addr_d1,
  input  logic                                 rd_en_d1,
  input  reg_addr_t                            rd_addr_d1,
  input  logic                                 load_d1,
  input  logic                                 ready_e,
  input  logic                                 flush,
  input  logic                                 wb_valid,
  input  reg_addr_t                            wb_rd_addr,
  output logic                                 issue_e,
  output logic                                 kill_e,
  output logic                                 stall_d1,
  output scoreboard_t                          busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [31:0]                          stall_cnt_o
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  issue_fsm_e  state;
  issue_fsm_e  state_next;
  logic [2:0]  flush_cnt;
  logic [2:0]  flush_cnt_next;
  scoreboard_t eb;
  logic        full;
  logic        hazard;
  logic        load_issue;

  assign load_issue = issue_e & load_d1 & rd_en_d1;

  id_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_issue (load_issue),
    .load_rd    (rd_addr_d1),
    .wb_valid   (wb_valid),
    .wb_rd_addr (wb_rd_addr),
    .busy       (busy_o),
    .eb         (eb),
    .outstanding(outstanding_o),
    .full       (full)
  );

  // A writeback this cycle frees a slot, so a full tracker does not block it.
  always_comb begin
    hazard = (rs1_en_d1 & eb[rs1_addr_d1])
           | (rs2_en_d1 & eb[rs2_addr_d1])
           | (rd_en_d1  & eb[rd_addr_d1])
           | (load_d1 & full & ~wb_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (flush) begin
      if (FLUSH_CYCLES > 1) begin
        state_next     = FLUSH;
        flush_cnt_next = FLUSH_RELOAD;
      end else begin
        state_next = RUN;
      end
    end else if (state == FLUSH) begin
      flush_cnt_next = flush_cnt - 3'd1;
      if (flush_cnt <= 3'd1) begin
        state_next = RUN;
      end
    end
  end

  // A stall with E ready still has to bubble E, otherwise E would re-execute.
  always_comb begin
    issue_e  = 1'b0;
    kill_e   = 1'b0;
    stall_d1 = 1'b0;
    if (!rst_n) begin
      kill_e = 1'b1;
    end else if (flush || (state == FLUSH)) begin
      kill_e = 1'b1;
    end else if (valid_d1 && !hazard && ready_e) begin
      issue_e = 1'b1;
    end else if (valid_d1) begin
      stall_d1 = 1'b1;
      kill_e   = ready_e;
    end else begin
      kill_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall_d1 && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_issue_ctl.sv
// Bench for id_issue_ctl: directed vector table, asynchronous reset check,
// then randomized traffic against a behavioural scoreboard model.
module tb_id_issue_ctl;
  import instr_defs::*;

  localparam int MAX_OUT = 4;
  localparam int FC      = 3;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_d1, rs1_en_d1, rs2_en_d1, rd_en_d1, load_d1;
  reg_addr_t     rs1_addr_d1, rs2_addr_d1, rd_addr_d1, wb_rd_addr;
  logic          ready_e, flush, wb_valid;
  logic          issue_e, kill_e, stall_d1;
  scoreboard_t   busy_o;
  logic [CW-1:0] outstanding_o;
  logic [31:0]   stall_cnt_o;

  always #5 clk = ~clk;

  id_issue_ctl #(
    .MAX_OUTSTANDING(MAX_OUT),
    .FLUSH_CYCLES   (FC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_d1     (valid_d1),
    .rs1_en_d1    (rs1_en_d1),
    .rs2_en_d1    (rs2_en_d1),
    .rs1_addr_d1  (rs1_addr_d1),
    .rs2_addr_d1  (rs2_addr_d1),
    .rd_en_d1     (rd_en_d1),
    .rd_addr_d1   (rd_addr_d1),
    .load_d1      (load_d1),
    .ready_e      (ready_e),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd_addr   (wb_rd_addr),
    .issue_e      (issue_e),
    .kill_e       (kill_e),
    .stall_d1     (stall_d1),
    .busy_o       (busy_o),
    .outstanding_o(outstanding_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  typedef struct {
    logic      valid, rs1_en, rs2_en, rd_en, load, ready, flush, wbv;
    reg_addr_t rs1, rs2, rd, wbrd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_issue, e_kill, e_stall;
    logic [31:0] e_busy;
    int          e_out;
    int          e_scnt;
  } vec_t;

  vec_t vtab[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: which registers await a load, how many loads are
  // in flight, how many forced-bubble cycles remain, and the stall tally.
  bit     m_busy[32];
  int     m_out;
  int     m_kill_rem;
  longint m_scnt;

  function automatic stim_t mk(input logic valid, rs1_en, input reg_addr_t rs1,
                               input logic rs2_en, input reg_addr_t rs2,
                               input logic rd_en, input reg_addr_t rd,
                               input logic load, ready, flush, wbv,
                               input reg_addr_t wbrd);
    stim_t s;
    s.valid = valid; s.rs1_en = rs1_en; s.rs1 = rs1; s.rs2_en = rs2_en;
    s.rs2 = rs2; s.rd_en = rd_en; s.rd = rd; s.load = load; s.ready = ready;
    s.flush = flush; s.wbv = wbv; s.wbrd = wbrd;
    return s;
  endfunction

  function automatic stim_t ld(input reg_addr_t rd, input logic wbv, input reg_addr_t wbrd);
    return mk(1, 0, 5'd0, 0, 5'd0, 1, rd, 1, 1, 0, wbv, wbrd);
  endfunction

  function automatic stim_t op(input reg_addr_t rs1, rs2, rd, input logic ready, fl, wbv,
                               input reg_addr_t wbrd);
    return mk(1, 1, rs1, 1, rs2, 1, rd, 0, ready, fl, wbv, wbrd);
  endfunction

  function automatic stim_t idle(input logic wbv, input reg_addr_t wbrd);
    return mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, wbv, wbrd);
  endfunction

  function automatic void addv(input stim_t s, input logic ei, ek, es,
                               input logic [31:0] eb, input int eo, ec);
    vec_t v;
    v.s = s; v.e_issue = ei; v.e_kill = ek; v.e_stall = es;
    v.e_busy = eb; v.e_out = eo; v.e_scnt = ec;
    vtab.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    @(negedge clk);
    valid_d1 = s.valid; rs1_en_d1 = s.rs1_en; rs1_addr_d1 = s.rs1;
    rs2_en_d1 = s.rs2_en; rs2_addr_d1 = s.rs2; rd_en_d1 = s.rd_en;
    rd_addr_d1 = s.rd; load_d1 = s.load; ready_e = s.ready; flush = s.flush;
    wb_valid = s.wbv; wb_rd_addr = s.wbrd;
    #1;
  endtask

  task automatic check_all(input string tag, input logic ei, ek, es,
                           input logic [31:0] eb, input int eo, input longint ec);
    check_output({tag, " issue_e"}, 32'(issue_e), 32'(ei));
    check_output({tag, " kill_e"}, 32'(kill_e), 32'(ek));
    check_output({tag, " stall_d1"}, 32'(stall_d1), 32'(es));
    check_output({tag, " busy_o"}, busy_o, eb);
    check_output({tag, " outstanding_o"}, 32'(outstanding_o), 32'(eo));
    check_output({tag, " stall_cnt_o"}, stall_cnt_o, 32'(ec));
  endtask

  function automatic bit m_eb(input reg_addr_t r, input stim_t s);
    return (r != 0) && m_busy[r] && !(s.wbv && (s.wbrd == r));
  endfunction

  function automatic void model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_out = 0; m_kill_rem = 0; m_scnt = 0;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    s = idle(0, 5'd0);
    valid_d1 = 0; rs1_en_d1 = 0; rs2_en_d1 = 0; rd_en_d1 = 0; load_d1 = 0;
    rs1_addr_d1 = 0; rs2_addr_d1 = 0; rd_addr_d1 = 0; wb_rd_addr = 0;
    ready_e = 1; flush = 0; wb_valid = 0;
    #22;
    check_all("reset", 0, 1, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use stall and writeback bypass
    addv(ld(5, 0, 0),                1, 0, 0, 32'h0,   0, 0);
    addv(op(5, 0, 8, 1, 0, 0, 0),    0, 1, 1, 32'h20,  1, 0);
    addv(op(5, 0, 8, 1, 0, 1, 5),    1, 0, 0, 32'h20,  1, 1);
    addv(idle(0, 0),                 0, 1, 0, 32'h0,   0, 1);
    // Outstanding-load limit, relieved by a same-cycle writeback
    addv(ld(1, 0, 0),                1, 0, 0, 32'h0,   0, 1);
    addv(ld(2, 0, 0),                1, 0, 0, 32'h02,  1, 1);
    addv(ld(3, 0, 0),                1, 0, 0, 32'h06,  2, 1);
    addv(ld(4, 0, 0),                1, 0, 0, 32'h0E,  3, 1);
    addv(ld(6, 0, 0),                0, 1, 1, 32'h1E,  4, 1);
    addv(ld(6, 1, 1),                1, 0, 0, 32'h1E,  4, 2);
    addv(idle(0, 0),                 0, 1, 0, 32'h5C,  4, 2);
    addv(idle(1, 2),                 0, 1, 0, 32'h5C,  4, 2);
    addv(idle(1, 3),                 0, 1, 0, 32'h58,  3, 2);
    addv(idle(1, 4),                 0, 1, 0, 32'h50,  2, 2);
    addv(idle(1, 6),                 0, 1, 0, 32'h40,  1, 2);
    // x0 as load target and as sources
    addv(mk(1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), 1, 0, 0, 32'h0, 0, 2);
    addv(mk(1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0), 1, 0, 0, 32'h0, 1, 2);
    addv(idle(1, 0),                 0, 1, 0, 32'h0,   1, 2);
    // Flush while stalled: three bubble cycles, then the stall resumes
    addv(ld(9, 0, 0),                1, 0, 0, 32'h0,   0, 2);
    addv(op(0, 9, 10, 1, 0, 0, 0),   0, 1, 1, 32'h200, 1, 2);
    addv(op(0, 9, 10, 1, 1, 0, 0),   0, 1, 0, 32'h200, 1, 3);
    addv(op(0, 9, 10, 1, 0, 0, 0),   0, 1, 0, 32'h200, 1, 3);
    addv(op(0, 9, 10, 1, 0, 0, 0),   0, 1, 0, 32'h200, 1, 3);
    addv(op(0, 9, 10, 1, 0, 0, 0),   0, 1, 1, 32'h200, 1, 3);
    addv(op(3, 0, 10, 1, 0, 0, 0),   1, 0, 0, 32'h200, 1, 4);
    // Same-cycle set and clear of x7, then stalls with E not ready
    addv(ld(7, 1, 7),                1, 0, 0, 32'h200, 1, 4);
    addv(idle(0, 0),                 0, 1, 0, 32'h280, 1, 4);
    addv(op(7, 0, 11, 0, 0, 0, 0),   0, 0, 1, 32'h280, 1, 4);
    addv(op(1, 0, 11, 0, 0, 0, 0),   0, 0, 1, 32'h280, 1, 5);
    addv(ld(5, 1, 9),                1, 0, 0, 32'h280, 1, 6);
    addv(op(5, 0, 12, 1, 0, 0, 0),   0, 1, 1, 32'hA0,  1, 6);

    for (int i = 0; i < vtab.size(); i++) begin
      apply_stimulus(vtab[i].s);
      check_all($sformatf("row%0d", i), vtab[i].e_issue, vtab[i].e_kill, vtab[i].e_stall,
                vtab[i].e_busy, vtab[i].e_out, vtab[i].e_scnt);
    end

    // Asynchronous reset in the middle of a stall, between clock edges
    #1 rst_n = 1'b0;
    #1 check_all("async_reset", 0, 1, 0, 32'h0, 0, 0);
    apply_stimulus(idle(0, 0));
    rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      logic        e_issue, e_kill, e_stall, haz, inc, dec;
      logic [31:0] e_busy;
      reg_addr_t   busy_list[$];
      s.valid  = ($urandom_range(0, 9) < 8);
      s.rs1_en = $urandom_range(0, 1) == 1;
      s.rs2_en = $urandom_range(0, 1) == 1;
      s.rd_en  = ($urandom_range(0, 9) < 8);
      s.rs1    = 5'($urandom_range(0, 7));
      s.rs2    = 5'($urandom_range(0, 7));
      s.rd     = 5'($urandom_range(0, 7));
      s.load   = ($urandom_range(0, 9) < 4);
      s.ready  = ($urandom_range(0, 9) < 8);
      s.flush  = ($urandom_range(0, 29) == 0);
      s.wbv    = (m_out > 0) && ($urandom_range(0, 9) < 3);
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
        s.wbrd = busy_list[$urandom_range(0, busy_list.size() - 1)];
      else
        s.wbrd = 5'($urandom_range(0, 7));
      apply_stimulus(s);

      e_busy = '0;
      for (int r = 0; r < 32; r++) e_busy[r] = m_busy[r];
      haz = (s.rs1_en && m_eb(s.rs1, s)) || (s.rs2_en && m_eb(s.rs2, s)) ||
            (s.rd_en && m_eb(s.rd, s)) || (s.load && m_out == MAX_OUT && !s.wbv);
      e_issue = 0; e_kill = 0; e_stall = 0;
      if (s.flush || m_kill_rem > 0) e_kill = 1;
      else if (s.valid && !haz && s.ready) e_issue = 1;
      else if (s.valid) begin e_stall = 1; e_kill = s.ready; end
      else e_kill = 1;
      check_all($sformatf("rand%0d", n), e_issue, e_kill, e_stall, e_busy, m_out, m_scnt);

      inc = e_issue && s.load && s.rd_en;
      dec = s.wbv && (m_out > 0);
      if (s.wbv) m_busy[s.wbrd] = 0;
      if (inc && s.rd != 0) m_busy[s.rd] = 1;
      m_out = m_out + int'(inc) - int'(dec);
      if (e_stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (s.flush) m_kill_rem = FC - 1;
      else if (m_kill_rem > 0) m_kill_rem--;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
